// File: rtl/uart_tx_cfg_pkg.sv
// Shared UART definitions: FSM state type and default frame constants,
// also used by the uart_rx successor.
package uart_tx_cfg_pkg;

  localparam int unsigned UART_DEF_OVS  = 16;
  localparam int unsigned UART_DEF_DBIT = 8;

  typedef enum logic [2:0] {
    UART_ST_IDLE   = 3'd0,
    UART_ST_START  = 3'd1,
    UART_ST_DATA   = 3'd2,
    UART_ST_PARITY = 3'd3,
    UART_ST_STOP   = 3'd4
  } uart_st_e;

  function automatic logic uart_par_bit(input logic data_xor, input logic odd);
    return data_xor ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_hold_buf.sv
// One-entry holding register for the UART transmitter: stores a byte and
// its frame configuration until the current frame finishes.
module uart_tx_hold_buf
  import uart_tx_cfg_pkg::*;
#(
  parameter int unsigned DBIT = UART_DEF_DBIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_pop,
  input  logic [DBIT-1:0] i_din,
  input  logic            i_stop2,
  input  logic            i_par_en,
  input  logic            i_par_odd,
  output logic            o_full,
  output logic [DBIT-1:0] o_din,
  output logic            o_stop2,
  output logic            o_par_en,
  output logic            o_par_odd
);

  logic            r_full;
  logic [DBIT-1:0] r_din;
  logic            r_stop2;
  logic            r_par_en;
  logic            r_par_odd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full    <= 1'b0;
      r_din     <= '0;
      r_stop2   <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
    end else if (i_load) begin
      r_full    <= 1'b1;
      r_din     <= i_din;
      r_stop2   <= i_stop2;
      r_par_en  <= i_par_en;
      r_par_odd <= i_par_odd;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_full    = r_full;
  assign o_din     = r_din;
  assign o_stop2   = r_stop2;
  assign o_par_en  = r_par_en;
  assign o_par_odd = r_par_odd;

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame stop/parity config and a one-entry holding
// register for back-to-back frames. Parity is built only with UART_TX_PARITY_EN.
module uart_tx_cfg
  import uart_tx_cfg_pkg::*;
#(
  parameter int unsigned DBIT = UART_DEF_DBIT,
  parameter int unsigned OVS  = UART_DEF_OVS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  input  logic            stop2,
  input  logic            par_en,
  input  logic            par_odd,
  output logic            tx_ready,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int unsigned SW = $clog2(2 * OVS);
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_BIT_LAST   = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP2_LAST = SW'(2 * OVS - 1);
  localparam logic [NW-1:0] N_LAST       = NW'(DBIT - 1);

  uart_st_e        r_state;
  logic [SW-1:0]   r_s;
  logic [NW-1:0]   r_n;
  logic [DBIT-1:0] r_shift;
  logic            r_stop2;
  logic            r_tx;
  logic            r_done;
`ifdef UART_TX_PARITY_EN
  logic [DBIT-1:0] r_data;
  logic            r_par_en;
  logic            r_par_odd;
  logic            w_ld_par_en;
  logic            w_ld_par_odd;
`endif

  logic            w_hold_full;
  logic [DBIT-1:0] w_hold_din;
  logic            w_hold_stop2;
  logic            w_hold_par_en;
  logic            w_hold_par_odd;
  logic            w_accept;
  logic            w_stop_end;
  logic            w_direct;
  logic            w_push;
  logic            w_pop;
  logic            w_load;
  logic [DBIT-1:0] w_ld_din;
  logic            w_ld_stop2;
  logic [SW-1:0]   w_stop_last;
  logic            w_tx_next;

  uart_tx_hold_buf #(.DBIT(DBIT)) u_hold (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_push),
    .i_pop     (w_pop),
    .i_din     (din),
    .i_stop2   (stop2),
    .i_par_en  (par_en),
    .i_par_odd (par_odd),
    .o_full    (w_hold_full),
    .o_din     (w_hold_din),
    .o_stop2   (w_hold_stop2),
    .o_par_en  (w_hold_par_en),
    .o_par_odd (w_hold_par_odd)
  );

  // A write landing on the final stop tick with the holding register empty
  // takes the same direct path as a write in IDLE.
  assign w_stop_last = r_stop2 ? S_STOP2_LAST : S_BIT_LAST;
  assign w_stop_end  = (r_state == UART_ST_STOP) && s_tick && (r_s == w_stop_last);
  assign w_accept    = tx_start && !w_hold_full;
  assign w_direct    = w_accept && ((r_state == UART_ST_IDLE) || w_stop_end);
  assign w_push      = w_accept && !w_direct;
  assign w_pop       = w_stop_end && w_hold_full;
  assign w_load      = w_direct || w_pop;
  assign w_ld_din    = w_hold_full ? w_hold_din   : din;
  assign w_ld_stop2  = w_hold_full ? w_hold_stop2 : stop2;
`ifdef UART_TX_PARITY_EN
  assign w_ld_par_en  = w_hold_full ? w_hold_par_en  : par_en;
  assign w_ld_par_odd = w_hold_full ? w_hold_par_odd : par_odd;
`else
  logic w_unused_par;
  assign w_unused_par = ^{par_en, par_odd, w_hold_par_en, w_hold_par_odd};
`endif

  always_comb begin
    w_tx_next = 1'b1;
    case (r_state)
      UART_ST_START:  w_tx_next = 1'b0;
      UART_ST_DATA:   w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
      UART_ST_PARITY: w_tx_next = uart_par_bit(^r_data, r_par_odd);
`endif
      default:        w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= UART_ST_IDLE;
      r_s       <= '0;
      r_n       <= '0;
      r_shift   <= '0;
      r_stop2   <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_tx   <= w_tx_next;
      case (r_state)
        UART_ST_IDLE: begin
          if (w_load) r_state <= UART_ST_START;
        end
        UART_ST_START: begin
          if (s_tick) begin
            if (r_s == S_BIT_LAST) begin
              r_s     <= '0;
              r_n     <= '0;
              r_state <= UART_ST_DATA;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        UART_ST_DATA: begin
          if (s_tick) begin
            if (r_s == S_BIT_LAST) begin
              r_s     <= '0;
              r_shift <= r_shift >> 1;
              if (r_n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                r_state <= r_par_en ? UART_ST_PARITY : UART_ST_STOP;
`else
                r_state <= UART_ST_STOP;
`endif
              end else begin
                r_n <= r_n + 1'b1;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        UART_ST_PARITY: begin
          if (s_tick) begin
            if (r_s == S_BIT_LAST) begin
              r_s     <= '0;
              r_state <= UART_ST_STOP;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
`endif
        UART_ST_STOP: begin
          if (s_tick) begin
            if (r_s == w_stop_last) begin
              r_done  <= 1'b1;
              r_s     <= '0;
              r_state <= w_load ? UART_ST_START : UART_ST_IDLE;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        default: r_state <= UART_ST_IDLE;
      endcase
      if (w_load) begin
        r_shift   <= w_ld_din;
        r_stop2   <= w_ld_stop2;
`ifdef UART_TX_PARITY_EN
        r_data    <= w_ld_din;
        r_par_en  <= w_ld_par_en;
        r_par_odd <= w_ld_par_odd;
`endif
      end
    end
  end

  assign tx           = r_tx;
  assign tx_done_tick = r_done;
  assign tx_busy      = (r_state != UART_ST_IDLE);
  assign tx_ready     = !w_hold_full;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Randomized self-checking bench for uart_tx_cfg: every baud tick of every
// frame is compared against a frame-level model of the expected line level.
module tb_uart_tx_cfg;

  localparam int DBIT = 8;
  localparam int OVS  = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic       stop2;
  logic       par_en;
  logic       par_odd;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done_tick;
  logic       tx;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DBIT(DBIT), .OVS(OVS)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
    .din          (din),
    .stop2        (stop2),
    .par_en       (par_en),
    .par_odd      (par_odd),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx           (tx)
  );

  typedef struct {
    logic [7:0] data;
    bit         stop2;
    bit         par;
    bit         odd;
  } frame_t;

  frame_t      q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          accepted = 0;
  int          done_cnt = 0;
  int          idx      = 0;
  int          ticks_since_done = 0;
  bit          b2b       = 1'b0;
  bit          prev_busy = 1'b0;
  bit          tick_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int frame_len(input frame_t f);
    return OVS * (1 + DBIT + (f.par ? 1 : 0) + (f.stop2 ? 2 : 1));
  endfunction

  // Line level during tick i (0-based) of frame f.
  function automatic logic exp_bit(input frame_t f, input int i);
    int b;
    int ones;
    b = i / OVS;
    if (b == 0) return 1'b0;
    if (b <= DBIT) return f.data[b-1];
    if (f.par && b == DBIT + 1) begin
      ones = 0;
      for (int k = 0; k < DBIT; k++) ones += int'(f.data[k]);
      return logic'(ones % 2) ^ f.odd;
    end
    return 1'b1;
  endfunction

  // tx now reflects the state during the previous cycle, i.e. the tick just taken.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      idx = 0; accepted = 0; done_cnt = 0; ticks_since_done = 0;
      b2b = 1'b0; prev_busy = 1'b0;
    end else begin
      if (s_tick) begin
        ticks_since_done++;
        if (prev_busy) begin
          if (q.size() == 0) check("busy_unexpected", 32'(prev_busy), 0);
          else begin
            if (idx == 0 && b2b) check("b2b_gap", ticks_since_done, 1);
            if (idx >= frame_len(q[0])) check("frame_overrun", idx, frame_len(q[0]) - 1);
            else check("tx_bit", 32'(tx), 32'(exp_bit(q[0], idx)));
            idx++;
          end
        end else begin
          check("idle_tx", 32'(tx), 1);
        end
      end
      if (tx_done_tick) begin
        if (q.size() == 0) check("done_unexpected", 32'(tx_done_tick), 0);
        else begin
          check("done_len", idx, frame_len(q[0]));
          void'(q.pop_front());
          done_cnt++;
        end
        b2b = (q.size() > 0);
        idx = 0;
        ticks_since_done = 0;
        check("busy_after_done", 32'(tx_busy), 32'(b2b));
      end
      prev_busy = tx_busy;
    end
  end

  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk); #1;
      s_tick = tick_en && ($urandom_range(0, 1) == 1);
    end
  end

  task automatic send(input logic [7:0] d, input bit s2, input bit pe, input bit po);
    bit     exp_acc;
    frame_t f;
    @(negedge clk); #1;
    exp_acc = (accepted - done_cnt) < 2;
    check("tx_ready", 32'(tx_ready), 32'(exp_acc));
    tx_start = 1'b1; din = d; stop2 = s2; par_en = pe; par_odd = po;
    if (exp_acc) begin
      f.data = d; f.stop2 = s2; f.par = PAR_BUILT && pe; f.odd = po;
      q.push_back(f);
      accepted++;
    end
    @(negedge clk); #1;
    tx_start = 1'b0;
    din = 8'($urandom); stop2 = 1'($urandom); par_en = 1'($urandom); par_odd = 1'($urandom);
  endtask

  task automatic drain();
    for (int c = 0; c < 4000 && done_cnt != accepted; c++) begin
      @(negedge clk); #1;
    end
    check("drain", done_cnt, accepted);
    repeat (2) @(negedge clk);
    #1;
    check("idle_busy", 32'(tx_busy), 0);
    check("idle_line", 32'(tx), 1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic saved_tx;
  logic saved_busy;

  initial begin
    reset = 1'b1; tx_start = 1'b0; din = '0; stop2 = 1'b0; par_en = 1'b0; par_odd = 1'b0;
    tick_en = 1'b1;
    wait_cycles(3); #1;
    check("rst_tx", 32'(tx), 1);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_done", 32'(tx_done_tick), 0);
    reset = 1'b0;

    send(8'h55, 1'b0, 1'b0, 1'b0);
    drain();
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    drain();

    send(8'h01, 1'b0, 1'b0, 1'b0);
    wait_cycles(40);
    send(8'h80, 1'b0, 1'b0, 1'b0);
    wait_cycles(5);
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    drain();

    send(8'h5A, 1'b0, 1'b1, 1'b1);
    drain();
`ifdef UART_TX_PARITY_EN
    send(8'hA3, 1'b0, 1'b1, 1'b0);
    drain();
    send(8'hA3, 1'b1, 1'b1, 1'b1);
    drain();
`endif

    send(8'h96, 1'b0, 1'b0, 1'b0);
    wait_cycles(100);
    tick_en = 1'b0;
    wait_cycles(3); #1;
    saved_tx = tx; saved_busy = tx_busy;
    wait_cycles(60); #1;
    check("pause_tx", 32'(tx), 32'(saved_tx));
    check("pause_busy", 32'(tx_busy), 32'(saved_busy));
    tick_en = 1'b1;
    drain();

    send(8'hC3, 1'b0, 1'b0, 1'b0);
    send(8'h7E, 1'b1, 1'b0, 1'b0);
    wait_cycles(150);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 1);
    check("midrst_busy", 32'(tx_busy), 0);
    check("midrst_ready", 32'(tx_ready), 1);
    @(negedge clk); #1;
    reset = 1'b0;
    send(8'h3A, 1'b0, 1'b0, 1'b0);
    drain();

    for (int t = 0; t < 30; t++) begin
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        wait_cycles($urandom_range(0, 300));
        send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      wait_cycles($urandom_range(0, 400));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
